iram_loader: RTL

IRAM_LOADER -- requirements
Module: iram_loader

---
 rtl/iram_loader.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/iram_loader.sv
// Byte-stream boot loader: a frame of SYNC, count N, then N big-endian 16-bit words
// is written into instruction RAM while the core is held in reset.
module iram_loader #(
  parameter int          IRAM_ADDR_BITS = 8,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT        = 1000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic                      rx_ready,
  output logic [IRAM_ADDR_BITS-1:0] iram_wa,
  output logic                      iram_wen,
  output logic [15:0]               iram_din,
  output logic                      cpu_hold,
  output logic                      load_done,
  output logic                      load_err
);

  // Count must hold 2^IRAM_ADDR_BITS (N=0) as well as any byte value.
  localparam int             CW       = (IRAM_ADDR_BITS > 8 ? IRAM_ADDR_BITS : 8) + 1;
  localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]  CNT_FULL = CNT_ONE << IRAM_ADDR_BITS;
  localparam logic [19:0]    TMO_LAST = 20'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [IRAM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [IRAM_ADDR_BITS-1:0] wa_q, wa_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [7:0]                hi_q, hi_d;
  logic [15:0]               din_q, din_d;
  logic [19:0]               tmo_q, tmo_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      acc;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wa_d     = wa_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    din_d    = din_q;
    tmo_d    = tmo_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rx_ready = (state_q != S_WRITE);
    acc      = rx_valid && rx_ready;

    case (state_q)
      S_IDLE: begin
        if (acc && rx_data == SYNC_BYTE) begin
          state_d = S_LEN;
          tmo_d   = '0;
        end
      end
      S_LEN: begin
        if (acc) begin
          cnt_d   = (rx_data == 8'd0) ? CNT_FULL : {{(CW-8){1'b0}}, rx_data};
          addr_d  = '0;
          tmo_d   = '0;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (acc) begin
          hi_d    = rx_data;
          tmo_d   = '0;
          state_d = S_LO;
        end
      end
      S_LO: begin
        // Output registers are loaded here so they hold steady outside WRITE.
        if (acc) begin
          wa_d    = addr_q;
          din_d   = {hi_q, rx_data};
          tmo_d   = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_HI;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Stalled mid-frame: count idle cycles and abandon the frame at the limit.
    if ((state_q == S_LEN || state_q == S_HI || state_q == S_LO) && !acc) begin
      if (tmo_q == TMO_LAST) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 20'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wa_q    <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      din_q   <= '0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wa_q    <= wa_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      din_q   <= din_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign iram_wen  = (state_q == S_WRITE);
  assign iram_wa   = wa_q;
  assign iram_din  = din_q;
  assign cpu_hold  = (state_q != S_IDLE);
  assign load_done = done_q;
  assign load_err  = err_q;

endmodule
